// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a ten-state sequencer that drives the
// datapath controls and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OP,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemToWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } stateT;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] countReg;
  logic             retire;

  logic       pcWriteDec, iorDDec, memReadDec, memWriteDec, irWriteDec;
  logic       memToRegDec, regDstDec, regWriteDec, aluSrcADec, illegalDec;
  logic [1:0] aluSrcBDec, aluOpDec, pcSourceDec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= FETCH;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (retire) countReg <= countReg + 1'b1;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    retire      = 1'b0;
    pcWriteDec  = 1'b0;
    iorDDec     = 1'b0;
    memReadDec  = 1'b0;
    memWriteDec = 1'b0;
    irWriteDec  = 1'b0;
    memToRegDec = 1'b0;
    regDstDec   = 1'b0;
    regWriteDec = 1'b0;
    aluSrcADec  = 1'b0;
    aluSrcBDec  = 2'b00;
    aluOpDec    = 2'b00;
    pcSourceDec = 2'b00;
    illegalDec  = 1'b0;
    case (stateReg)
      FETCH: begin
        memReadDec = 1'b1;
        aluSrcBDec = 2'b01;
        irWriteDec = mem_ready;
        pcWriteDec = mem_ready;
        if (mem_ready) stateNext = DECODE;
      end
      DECODE: begin
        aluSrcBDec = 2'b11;
        case (OP)
          OP_LW, OP_SW: stateNext = MEM_ADDR;
          OP_R:         stateNext = R_EXEC;
          OP_BEQ:       stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          default: begin
            stateNext  = FETCH;
            illegalDec = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        aluSrcADec = 1'b1;
        aluSrcBDec = 2'b10;
        stateNext  = (OP == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        memReadDec = 1'b1;
        iorDDec    = 1'b1;
        if (mem_ready) stateNext = MEM_WB;
      end
      MEM_WB: begin
        regWriteDec = 1'b1;
        memToRegDec = 1'b1;
        stateNext   = FETCH;
        retire      = 1'b1;
      end
      MEM_WRITE: begin
        memWriteDec = 1'b1;
        iorDDec     = 1'b1;
        if (mem_ready) begin
          stateNext = FETCH;
          retire    = 1'b1;
        end
      end
      R_EXEC: begin
        aluSrcADec = 1'b1;
        aluOpDec   = 2'b10;
        stateNext  = R_WB;
      end
      R_WB: begin
        regWriteDec = 1'b1;
        regDstDec   = 1'b1;
        stateNext   = FETCH;
        retire      = 1'b1;
      end
      BRANCH: begin
        aluSrcADec  = 1'b1;
        aluOpDec    = 2'b01;
        pcSourceDec = 2'b01;
        pcWriteDec  = Zero;
        stateNext   = FETCH;
        retire      = 1'b1;
      end
      JUMP: begin
        pcSourceDec = 2'b10;
        pcWriteDec  = 1'b1;
        stateNext   = FETCH;
        retire      = 1'b1;
      end
      default: stateNext = FETCH;
    endcase
  end

  // Gating with rst_n keeps strobes low even before the async reset settles FETCH.
  assign PCWrite     = rst_n & pcWriteDec;
  assign IorD        = rst_n & iorDDec;
  assign MemRead     = rst_n & memReadDec;
  assign MemToWrite  = rst_n & memWriteDec;
  assign IRWrite     = rst_n & irWriteDec;
  assign MemToReg    = rst_n & memToRegDec;
  assign RegDst      = rst_n & regDstDec;
  assign RegWrite    = rst_n & regWriteDec;
  assign ALUSrcA     = rst_n & aluSrcADec;
  assign ALUSrcB     = {2{rst_n}} & aluSrcBDec;
  assign ALUOp       = {2{rst_n}} & aluOpDec;
  assign PCSource    = {2{rst_n}} & pcSourceDec;
  assign illegal_op  = rst_n & illegalDec;
  assign state       = stateReg;
  assign instr_count = countReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls,
// illegal opcode, mid-stall reset and counter wrap with a 4-bit counter.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       OP = 6'b000000;
  logic             Zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             PCWrite, IorD, MemRead, MemToWrite, IRWrite, MemToReg;
  logic             RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic [14:0]      ctrl;

  int errCount = 0;
  int checkCount = 0;

  // Control vector: PCWrite IorD MemRead MemToWrite IRWrite MemToReg RegDst
  // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
  localparam logic [14:0] C_FETCH   = 15'b101010000010000;
  localparam logic [14:0] C_FETCH_S = 15'b001000000010000;
  localparam logic [14:0] C_DECODE  = 15'b000000000110000;
  localparam logic [14:0] C_MADDR   = 15'b000000001100000;
  localparam logic [14:0] C_MREAD   = 15'b011000000000000;
  localparam logic [14:0] C_MWB     = 15'b000001010000000;
  localparam logic [14:0] C_MWRITE  = 15'b010100000000000;
  localparam logic [14:0] C_REXEC   = 15'b000000001001000;
  localparam logic [14:0] C_RWB     = 15'b000000110000000;
  localparam logic [14:0] C_BR_Z    = 15'b100000001000101;
  localparam logic [14:0] C_BR_NZ   = 15'b000000001000101;
  localparam logic [14:0] C_JUMP    = 15'b100000000000010;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemToWrite(MemToWrite),
    .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  assign ctrl = {PCWrite, IorD, MemRead, MemToWrite, IRWrite, MemToReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, return just after the rising edge.
  task automatic cyc(input string tag, input logic [3:0] expState, input logic [14:0] expCtrl,
                     input logic expIll, input logic [CNT_W-1:0] expCnt);
    @(negedge clk);
    checkVal({tag, ".state"}, 32'(state), 32'(expState));
    checkVal({tag, ".ctrl"}, 32'(ctrl), 32'(expCtrl));
    checkVal({tag, ".ill"}, 32'(illegal_op), 32'(expIll));
    checkVal({tag, ".cnt"}, 32'(instr_count), 32'(expCnt));
    checkVal({tag, ".rdwr"}, 32'(MemRead & MemToWrite), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    checkVal("rst.ctrl", 32'(ctrl), 32'd0);
    checkVal("rst.state", 32'(state), 32'd0);
    checkVal("rst.cnt", 32'(instr_count), 32'd0);
    checkVal("rst.ill", 32'(illegal_op), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // LW, no stalls; OP changed in MEM_READ must be ignored
    OP = OP_LW;
    cyc("lw.f", 4'd0, C_FETCH, 1'b0, 4'd0);
    cyc("lw.d", 4'd1, C_DECODE, 1'b0, 4'd0);
    cyc("lw.a", 4'd2, C_MADDR, 1'b0, 4'd0);
    OP = OP_R;
    cyc("lw.r", 4'd3, C_MREAD, 1'b0, 4'd0);
    cyc("lw.wb", 4'd4, C_MWB, 1'b0, 4'd0);
    $display("txn LW done count=%0d", instr_count);

    // SW with one FETCH stall and three MEM_WRITE stalls
    OP = OP_SW;
    mem_ready = 1'b0;
    cyc("sw.fs", 4'd0, C_FETCH_S, 1'b0, 4'd1);
    mem_ready = 1'b1;
    cyc("sw.f", 4'd0, C_FETCH, 1'b0, 4'd1);
    cyc("sw.d", 4'd1, C_DECODE, 1'b0, 4'd1);
    mem_ready = 1'b0;
    cyc("sw.a", 4'd2, C_MADDR, 1'b0, 4'd1);
    cyc("sw.w0", 4'd5, C_MWRITE, 1'b0, 4'd1);
    cyc("sw.w1", 4'd5, C_MWRITE, 1'b0, 4'd1);
    cyc("sw.w2", 4'd5, C_MWRITE, 1'b0, 4'd1);
    mem_ready = 1'b1;
    cyc("sw.w3", 4'd5, C_MWRITE, 1'b0, 4'd1);
    $display("txn SW stalled done count=%0d", instr_count);

    OP = OP_R;
    cyc("r.f", 4'd0, C_FETCH, 1'b0, 4'd2);
    cyc("r.d", 4'd1, C_DECODE, 1'b0, 4'd2);
    cyc("r.x", 4'd6, C_REXEC, 1'b0, 4'd2);
    cyc("r.wb", 4'd7, C_RWB, 1'b0, 4'd2);
    $display("txn R done count=%0d", instr_count);

    OP = OP_BEQ;
    Zero = 1'b1;
    cyc("bz.f", 4'd0, C_FETCH, 1'b0, 4'd3);
    cyc("bz.d", 4'd1, C_DECODE, 1'b0, 4'd3);
    cyc("bz.b", 4'd8, C_BR_Z, 1'b0, 4'd3);
    $display("txn BEQ taken done count=%0d", instr_count);

    Zero = 1'b0;
    cyc("bn.f", 4'd0, C_FETCH, 1'b0, 4'd4);
    cyc("bn.d", 4'd1, C_DECODE, 1'b0, 4'd4);
    cyc("bn.b", 4'd8, C_BR_NZ, 1'b0, 4'd4);
    $display("txn BEQ not-taken done count=%0d", instr_count);

    OP = OP_J;
    cyc("j.f", 4'd0, C_FETCH, 1'b0, 4'd5);
    cyc("j.d", 4'd1, C_DECODE, 1'b0, 4'd5);
    cyc("j.j", 4'd9, C_JUMP, 1'b0, 4'd5);
    $display("txn J done count=%0d", instr_count);

    OP = OP_BAD;
    cyc("ill.f", 4'd0, C_FETCH, 1'b0, 4'd6);
    cyc("ill.d", 4'd1, C_DECODE, 1'b1, 4'd6);
    OP = OP_LW;
    cyc("ill.f2", 4'd0, C_FETCH, 1'b0, 4'd6);
    $display("txn illegal done count=%0d", instr_count);

    // LW stalled in MEM_READ, then reset mid-cycle
    cyc("rl.d", 4'd1, C_DECODE, 1'b0, 4'd6);
    mem_ready = 1'b0;
    cyc("rl.a", 4'd2, C_MADDR, 1'b0, 4'd6);
    cyc("rl.r", 4'd3, C_MREAD, 1'b0, 4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("rl.rst.ctrl", 32'(ctrl), 32'd0);
    checkVal("rl.rst.state", 32'(state), 32'd0);
    checkVal("rl.rst.cnt", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    OP = OP_J;
    $display("txn reset during MEM_READ stall count=%0d", instr_count);

    // Fifteen jumps bring the 4-bit counter to its maximum
    for (int i = 0; i < 15; i++) begin
      cyc("wj.f", 4'd0, C_FETCH, 1'b0, 4'(i));
      cyc("wj.d", 4'd1, C_DECODE, 1'b0, 4'(i));
      cyc("wj.j", 4'd9, C_JUMP, 1'b0, 4'(i));
    end
    $display("txn 15 jumps done count=%0d", instr_count);

    OP = OP_R;
    cyc("wr.f", 4'd0, C_FETCH, 1'b0, 4'd15);
    cyc("wr.d", 4'd1, C_DECODE, 1'b0, 4'd15);
    cyc("wr.x", 4'd6, C_REXEC, 1'b0, 4'd15);
    cyc("wr.wb", 4'd7, C_RWB, 1'b0, 4'd15);
    cyc("wr.f2", 4'd0, C_FETCH, 1'b0, 4'd0);
    $display("txn R wrap done count=%0d", instr_count);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
